// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that packs four accepted bytes little-endian into a 32-bit word.
// Latency: the word appears on UART_in one cycle after the stop-bit sample of the 4th byte.
// Backpressure: none. Reception never stalls; a word that completes while one is still pending is dropped and sets overrun.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CLKS_WIDTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        rx_ack,
  output logic [31:0] UART_in,
  output logic        rx_signal,
  output logic        framing_err,
  output logic        overrun
);

  localparam logic [CLKS_WIDTH-1:0] HALF_CNT = CLKS_WIDTH'(CLKS_PER_BIT / 2);
  localparam logic [CLKS_WIDTH-1:0] LAST_CNT = CLKS_WIDTH'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  rx_meta;
  logic                  rx_s;
  logic [CLKS_WIDTH-1:0] cnt;
  logic [2:0]            bit_idx;
  logic [1:0]            byte_idx;
  logic [7:0]            shreg;
  logic [23:0]           asm_word;

  // Control strobes decoded by the next-state logic
  logic cnt_clr;
  logic cnt_inc;
  logic bit_clr;
  logic bit_take;
  logic byte_ok;
  logic byte_bad;
  logic word_done;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; every sample point is a counter compare
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    bit_take = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            // Line went back high mid start bit: treat as a glitch
            state_d = IDLE;
          end else begin
            bit_clr = 1'b1;
            state_d = DATA;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
          if (rx_s) begin
            byte_ok = 1'b1;
          end else begin
            byte_bad = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign word_done = byte_ok && (byte_idx == 2'd3);

  // Bit timing counter, bit shifter and byte assembly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      asm_word    <= '0;
      framing_err <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end

      if (bit_clr) begin
        bit_idx <= '0;
      end else if (bit_take) begin
        bit_idx <= bit_idx + 1'b1;
      end

      // LSB arrives first, so shift in from the top
      if (bit_take) begin
        shreg <= {rx_s, shreg[7:1]};
      end

      if (byte_ok) begin
        case (byte_idx)
          2'd0:    asm_word[7:0]   <= shreg;
          2'd1:    asm_word[15:8]  <= shreg;
          2'd2:    asm_word[23:16] <= shreg;
          default: ;  // top byte goes straight to UART_in
        endcase
        byte_idx <= byte_idx + 1'b1;  // wraps to 0 after the 4th byte
      end else if (byte_bad) begin
        // A bad frame poisons the whole word, restart at byte 0
        byte_idx <= '0;
      end

      framing_err <= byte_bad;
    end
  end

  // Word handoff to the consumer; a same-cycle ack frees the slot for the new word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      UART_in   <= '0;
      rx_signal <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done) begin
        if (!rx_signal || rx_ack) begin
          UART_in   <= {shreg, asm_word};
          rx_signal <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_signal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 16 clocks per bit.
// Drives whole 8N1 frames on rx and checks the word handoff, error and overrun flags.
// Consumer ack is driven explicitly, including one ack aligned with a word completion.
module tb_uart_word_rx;

  logic        clock;
  logic        reset;
  logic        rx;
  logic        rx_ack;
  logic [31:0] UART_in;
  logic        rx_signal;
  logic        framing_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int fe_cycles = 0;

  uart_word_rx #(
    .CLKS_PER_BIT(16),
    .CLKS_WIDTH  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .UART_in    (UART_in),
    .rx_signal  (rx_signal),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every cycle framing_err is high, sampled away from the active edge
  always @(negedge clock) begin
    if (reset && framing_err) fe_cycles <= fe_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One 8N1 frame; ack_at_stop raises rx_ack for the exact cycle of the stop sample
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clock);
    end
    rx = stop_bit;
    for (int j = 0; j < 16; j++) begin
      if (ack_at_stop && j == 11) rx_ack = 1'b1;
      if (j == 12) rx_ack = 1'b0;
      @(negedge clock);
    end
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w, input logic ack_last);
    send_byte(w[7:0],   1'b1, 1'b0);
    send_byte(w[15:8],  1'b1, 1'b0);
    send_byte(w[23:16], 1'b1, 1'b0);
    send_byte(w[31:24], 1'b1, ack_last);
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (4) @(negedge clock);
    check("reset_uart_in",     UART_in,     32'h0);
    check("reset_rx_signal",   rx_signal,   32'h0);
    check("reset_framing_err", framing_err, 32'h0);
    check("reset_overrun",     overrun,     32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Basic word, checking nothing fires before the 4th byte
    send_byte(8'h78, 1'b1, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    check("basic_no_early_word", rx_signal, 32'h0);
    check("basic_uart_in_unchanged", UART_in, 32'h0);
    send_byte(8'h12, 1'b1, 1'b0);
    check("basic_rx_signal", rx_signal, 32'h1);
    check("basic_word", UART_in, 32'h12345678);
    check("basic_no_framing_err", fe_cycles, 32'd0);
    pulse_ack();
    check("basic_ack_clears", rx_signal, 32'h0);
    check("basic_word_holds", UART_in, 32'h12345678);

    // Short low glitch is rejected
    @(negedge clock);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_no_word", rx_signal, 32'h0);
    check("glitch_no_framing_err", fe_cycles, 32'd0);
    send_word(32'hA1B2C3D4, 1'b0);
    check("glitch_then_word", UART_in, 32'hA1B2C3D4);
    check("glitch_then_signal", rx_signal, 32'h1);
    pulse_ack();

    // Framing error discards the partial word
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    check("ferr_one_pulse", fe_cycles, 32'd1);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    check("ferr_word_restarted", rx_signal, 32'h0);
    send_byte(8'h44, 1'b1, 1'b0);
    check("ferr_word", UART_in, 32'h44332211);
    check("ferr_signal", rx_signal, 32'h1);
    check("ferr_still_one_pulse", fe_cycles, 32'd1);
    pulse_ack();

    // Overrun: second word while the first is still pending
    send_word(32'hDEADBEEF, 1'b0);
    check("ovr_word_a", UART_in, 32'hDEADBEEF);
    check("ovr_not_yet", overrun, 32'h0);
    send_word(32'h0BADCAFE, 1'b0);
    check("ovr_word_kept", UART_in, 32'hDEADBEEF);
    check("ovr_flag", overrun, 32'h1);
    check("ovr_signal_held", rx_signal, 32'h1);
    pulse_ack();
    check("ovr_ack_clears", rx_signal, 32'h0);
    check("ovr_sticky", overrun, 32'h1);
    pulse_ack();
    check("idle_ack_no_effect", rx_signal, 32'h0);
    check("idle_ack_word_holds", UART_in, 32'hDEADBEEF);

    // Reset mid-frame after 2 bytes and 3 data bits
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h66, 1'b1, 1'b0);
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    rx = 1'b1; repeat (16) @(negedge clock);
    rx = 1'b0; repeat (16) @(negedge clock);
    rx = 1'b1; repeat (8) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midreset_overrun_clear", overrun, 32'h0);
    check("midreset_uart_in_clear", UART_in, 32'h0);
    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    send_word(32'h04030201, 1'b0);
    check("midreset_word", UART_in, 32'h04030201);
    check("midreset_signal", rx_signal, 32'h1);
    check("midreset_no_overrun", overrun, 32'h0);
    pulse_ack();

    // Ack coincides with completion of a second word
    send_word(32'hCAFEF00D, 1'b0);
    check("simul_first_word", UART_in, 32'hCAFEF00D);
    send_word(32'h8BADF00D, 1'b1);
    check("simul_signal_stays", rx_signal, 32'h1);
    check("simul_second_word", UART_in, 32'h8BADF00D);
    check("simul_no_overrun", overrun, 32'h0);
    check("final_no_extra_ferr", fe_cycles, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
